// File: rtl/pcounter_cfg_arb_if.sv
// Requester command/response and counter cfg bus for pcounter_cfg_arb.
// slave = arbiter side, master = requesters plus counter side.
interface pcounter_cfg_arb_if;
  logic        req0_valid, req0_rd_wr, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_rd_wr, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        cfg_enable, cfg_rd_wr;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        busy;

  modport slave (
    input  req0_valid, req0_rd_wr, req0_addr, req0_wdata,
    input  req1_valid, req1_rd_wr, req1_addr, req1_wdata, cfg_rdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata,
    output cfg_enable, cfg_rd_wr, cfg_addr, cfg_wdata, busy
  );
  modport master (
    output req0_valid, req0_rd_wr, req0_addr, req0_wdata,
    output req1_valid, req1_rd_wr, req1_addr, req1_wdata, cfg_rdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata,
    input  cfg_enable, cfg_rd_wr, cfg_addr, cfg_wdata, busy
  );
endinterface

// File: rtl/pcounter_cfg_arb.sv
// Two-requester round-robin arbiter serialising commands onto the counter cfg port,
// with illegal-command rejection and a programmable idle gap between accesses.
module pcounter_cfg_arb #(
  parameter int GAP_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  pcounter_cfg_arb_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, ACCESS = 3'd1, CAPTURE = 3'd2, RESP = 3'd3, GAP = 3'd4} state_e;
  typedef struct packed {
    logic        rd_wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam logic [3:0] GAP_LEN = 4'(GAP_CYCLES);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d, cmd_sel;
  cmd_t [1:0]  req_cmd;
  logic [1:0]  req_vld;
  logic        last_q, last_d, gnt_q, gnt_d, err_q, err_d;
  logic        cfg_enable_q, cfg_enable_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  gap_q, gap_d;
  logic        win, hs, illegal, rsp_fire;

  assign req_vld    = {bus.req1_valid, bus.req0_valid};
  assign req_cmd[0] = {bus.req0_rd_wr, bus.req0_addr, bus.req0_wdata};
  assign req_cmd[1] = {bus.req1_rd_wr, bus.req1_addr, bus.req1_wdata};

  // On contention the requester not served last wins; a lone requester always wins.
  assign win     = (&req_vld) ? ~last_q : req_vld[1];
  assign cmd_sel = req_cmd[win];
  assign hs      = rst & (state_q == IDLE) & (|req_vld);
  assign illegal = (cmd_sel.addr[1:0] != 2'b00) |
                   (~cmd_sel.rd_wr & ((cmd_sel.addr == 5'h10) | (cmd_sel.addr == 5'h14)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      gap_q        <= '0;
      cfg_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      gap_q        <= gap_d;
      cfg_enable_q <= cfg_enable_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (hs) begin
        // Rejected commands leave the cfg bus untouched.
        if (!illegal) cmd_d = cmd_sel;
        gnt_d   = win;
        last_d  = win;
        err_d   = illegal;
        rdata_d = '0;
        state_d = illegal ? RESP : ACCESS;
      end
      ACCESS:  state_d = cmd_q.rd_wr ? CAPTURE : RESP;
      CAPTURE: begin
        rdata_d = bus.cfg_rdata;
        state_d = RESP;
      end
      RESP: if ((GAP_LEN != 4'd0) && !err_q) begin
        state_d = GAP;
        gap_d   = GAP_LEN;
      end else begin
        state_d = IDLE;
      end
      GAP: if (gap_q <= 4'd1) begin
        gap_d   = 4'd0;
        state_d = IDLE;
      end else begin
        gap_d = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    cfg_enable_d = (state_d == ACCESS);
  end

  always_comb begin
    rsp_fire       = (state_q == RESP);
    bus.busy       = (state_q != IDLE);
    bus.req0_ready = hs & ~win;
    bus.req1_ready = hs & win;
    bus.rsp0_valid = rsp_fire & ~gnt_q;
    bus.rsp1_valid = rsp_fire & gnt_q;
    bus.rsp0_err   = bus.rsp0_valid & err_q;
    bus.rsp1_err   = bus.rsp1_valid & err_q;
    bus.rsp0_rdata = bus.rsp0_valid ? rdata_q : 32'h0;
    bus.rsp1_rdata = bus.rsp1_valid ? rdata_q : 32'h0;
    bus.cfg_enable = cfg_enable_q;
    bus.cfg_rd_wr  = cmd_q.rd_wr;
    bus.cfg_addr   = cmd_q.addr;
    bus.cfg_wdata  = cmd_q.wdata;
  end
endmodule

// File: tb/tb_pcounter_cfg_arb.sv
// Bench for pcounter_cfg_arb: command table plus contention, gap and reset-abort
// sequences; responses and cfg strobes are checked against queued expectations.
module tb_pcounter_cfg_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pcounter_cfg_arb_if bus ();
  pcounter_cfg_arb_if bus0 ();

  pcounter_cfg_arb #(.GAP_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  pcounter_cfg_arb #(.GAP_CYCLES(0)) dut_g0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    int          req;
    bit          rd;
    logic [4:0]  addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;
  typedef struct {
    int          req;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } rsp_t;
  typedef struct {
    bit          rd;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          due;
  } cfg_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int first_hs = -1;
  int last_hs = -1;
  int last_strobe = -100;
  rsp_t rsp_q[$];
  cfg_t cfg_q[$];
  int   gnt_log[$];
  rsp_t e_rsp;
  cfg_t e_cfg;
  logic [31:0] mem [32];
  bit          pend_rd = 1'b0;
  logic [4:0]  pend_addr = '0;
  vec_t        vecs [11];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Counter model plus scoreboard monitor, sampled 1ns after each rising edge.
  initial begin
    bus.cfg_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.cfg_rdata = pend_rd ? mem[pend_addr] : 32'hDEAD_BEEF;
      pend_rd   = bus.cfg_enable && bus.cfg_rd_wr;
      pend_addr = bus.cfg_addr;
      if (bus.cfg_enable) begin
        if (!bus.cfg_rd_wr) mem[bus.cfg_addr] = bus.cfg_wdata;
        chk("strobe_spacing", 32'(cyc - last_strobe >= 4), 32'd1);
        last_strobe = cyc;
        if (cfg_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_strobe: got cfg_enable=1 addr %0h expected no strobe (cycle %0d)", bus.cfg_addr, cyc);
        end else begin
          e_cfg = cfg_q.pop_front();
          chk("cfg_cycle", 32'(cyc), 32'(e_cfg.due));
          chk("cfg_rd_wr", 32'(bus.cfg_rd_wr), 32'(e_cfg.rd));
          chk("cfg_addr", 32'(bus.cfg_addr), 32'(e_cfg.addr));
          chk("cfg_wdata", bus.cfg_wdata, e_cfg.wdata);
        end
      end
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        chk("rsp_onehot", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
        if (rsp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rsp: got rsp0=%0b rsp1=%0b expected none (cycle %0d)", bus.rsp0_valid, bus.rsp1_valid, cyc);
        end else begin
          e_rsp = rsp_q.pop_front();
          chk("rsp_req", 32'(bus.rsp1_valid), 32'(e_rsp.req));
          chk("rsp_cycle", 32'(cyc), 32'(e_rsp.due));
          chk("rsp_err", 32'(bus.rsp1_valid ? bus.rsp1_err : bus.rsp0_err), 32'(e_rsp.err));
          chk("rsp_rdata", bus.rsp1_valid ? bus.rsp1_rdata : bus.rsp0_rdata, e_rsp.rdata);
        end
      end
    end
  end

  task automatic set_req(int r, bit v, bit rd, logic [4:0] a, logic [31:0] d);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_rd_wr = rd; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_rd_wr = rd; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  // Issue one command, wait (bounded) for the handshake, queue the expectations.
  task automatic drive(int r, bit rd, logic [4:0] a, logic [31:0] d, bit err,
                       logic [31:0] rdat, bit want_rsp);
    bit got = 1'b0;
    rsp_t rs;
    cfg_t cf;
    set_req(r, 1'b1, rd, a, d);
    for (int n = 0; n < 300; n++) begin
      #1;
      if ((r == 0) ? bus.req0_ready : bus.req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      gnt_log.push_back(r);
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (!err) begin
        cf.rd = rd; cf.addr = a; cf.wdata = d; cf.due = cyc + 1;
        cfg_q.push_back(cf);
      end
      if (want_rsp) begin
        rs.req = r; rs.err = err; rs.rdata = rdat;
        rs.due = cyc + (err ? 1 : (rd ? 3 : 2));
        rsp_q.push_back(rs);
      end
      @(posedge clk);
      #2;
    end else begin
      n_chk++; n_fail++;
      $display("FAIL handshake_timeout: got no ready for req%0d expected grant", r);
    end
    set_req(r, 1'b0, rd, a, d);
  endtask

  task automatic hs_g0(logic [4:0] a, output int h);
    h = -1;
    bus0.req0_valid = 1'b1; bus0.req0_rd_wr = 1'b0; bus0.req0_addr = a; bus0.req0_wdata = 32'h5;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (bus0.req0_ready) begin
        h = cyc;
        break;
      end
      @(negedge clk);
    end
    if (h >= 0) begin
      @(posedge clk);
      #2;
    end
    bus0.req0_valid = 1'b0;
  endtask

  initial begin
    int h1, h2, rel_cyc;
    int exp_g [4];
    exp_g = '{0, 1, 0, 1};
    for (int i = 0; i < 32; i++) mem[i] = 32'h0100_0000 + 32'(i);
    mem[4] = 32'd2;
    vecs[0]  = '{0, 1'b0, 5'h08, 32'd100,       1'b0, 32'h0};
    vecs[1]  = '{1, 1'b1, 5'h04, 32'h0,         1'b0, 32'd2};
    vecs[2]  = '{0, 1'b0, 5'h14, 32'h77,        1'b1, 32'h0};
    vecs[3]  = '{0, 1'b0, 5'h05, 32'h78,        1'b1, 32'h0};
    vecs[4]  = '{1, 1'b1, 5'h08, 32'h0,         1'b0, 32'd100};
    vecs[5]  = '{0, 1'b1, 5'h10, 32'h0,         1'b0, 32'h0100_0010};
    vecs[6]  = '{1, 1'b0, 5'h10, 32'h9,         1'b1, 32'h0};
    vecs[7]  = '{1, 1'b1, 5'h02, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{0, 1'b0, 5'h1C, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[9]  = '{1, 1'b1, 5'h1C, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[10] = '{0, 1'b1, 5'h14, 32'h0,         1'b0, 32'h0100_0014};

    bus0.req0_valid = 1'b0; bus0.req0_rd_wr = 1'b0; bus0.req0_addr = '0; bus0.req0_wdata = '0;
    bus0.req1_valid = 1'b0; bus0.req1_rd_wr = 1'b0; bus0.req1_addr = '0; bus0.req1_wdata = '0;
    bus0.cfg_rdata  = '0;
    set_req(0, 1'b1, 1'b0, 5'h00, 32'h11);
    set_req(1, 1'b1, 1'b0, 5'h18, 32'h22);
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cfg_enable", 32'(bus.cfg_enable), 32'd0);
    chk("rst_cfg_addr", 32'(bus.cfg_addr), 32'd0);
    chk("rst_cfg_wdata", bus.cfg_wdata, 32'd0);
    chk("rst_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err}), 32'd0);

    // Both requesters valid straight out of reset: grants must alternate 0,1,0,1.
    rst = 1'b1;
    rel_cyc = cyc;
    fork
      begin
        drive(0, 1'b0, 5'h00, 32'h11, 1'b0, 32'h0, 1'b1);
        drive(0, 1'b1, 5'h18, 32'h0,  1'b0, 32'h22, 1'b1);
      end
      begin
        drive(1, 1'b0, 5'h18, 32'h22, 1'b0, 32'h0, 1'b1);
        drive(1, 1'b1, 5'h00, 32'h0,  1'b0, 32'h11, 1'b1);
      end
    join
    chk("first_grant_cycle", 32'(first_hs), 32'(rel_cyc));
    chk("grant_count", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("grant_order", 32'(gnt_log[i]), 32'(exp_g[i]));

    foreach (vecs[i]) drive(vecs[i].req, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                            vecs[i].err, vecs[i].rdata, 1'b1);

    // Back-to-back legal writes: handshakes 6 cycles apart with a 3-cycle gap.
    drive(0, 1'b0, 5'h0C, 32'h1, 1'b0, 32'h0, 1'b1);
    h1 = last_hs;
    drive(0, 1'b0, 5'h0C, 32'h2, 1'b0, 32'h0, 1'b1);
    h2 = last_hs;
    chk("gap3_hs_spacing", 32'(h2 - h1), 32'd6);

    // No gap: next grant in the cycle right after RESP.
    hs_g0(5'h08, h1);
    hs_g0(5'h0C, h2);
    chk("gap0_hs_spacing", 32'(h2 - h1), 32'd3);

    // Reset asserted during the ACCESS cycle of a read aborts it silently.
    repeat (2) @(negedge clk);
    set_req(1, 1'b1, 1'b1, 5'h04, 32'h0);
    h1 = -1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (bus.req1_ready) begin
        h1 = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("abort_handshake", 32'(h1 >= 0), 32'd1);
    e_cfg.rd = 1'b1; e_cfg.addr = 5'h04; e_cfg.wdata = 32'h0; e_cfg.due = h1 + 1;
    cfg_q.push_back(e_cfg);
    @(posedge clk);
    #2;
    set_req(1, 1'b0, 1'b1, 5'h04, 32'h0);
    chk("abort_pre_enable", 32'(bus.cfg_enable), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_enable_drop", 32'(bus.cfg_enable), 32'd0);
    chk("abort_busy_drop", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    drive(1, 1'b1, 5'h04, 32'h0, 1'b0, 32'd2, 1'b1);

    for (int n = 0; n < 50 && (rsp_q.size() != 0 || cfg_q.size() != 0); n++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("cfg_queue_drained", 32'(cfg_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200us");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pcounter_cfg_arb.md
PCOUNTER_CFG_ARB -- requirements
Module: pcounter_cfg_arb

Interface
REQ-001 SHALL have one parameter: GAP_CYCLES, default 1, minimum cfg_enable-low cycles (0..15) between consecutive counter cfg accesses.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) command valid.
REQ-005 SHALL have ports reqN_rd_wr  input  1  1=read, 0=write.
REQ-006 SHALL have ports reqN_addr  input  5  register address.
REQ-007 SHALL have ports reqN_wdata  input  32  write data.
REQ-008 SHALL have ports reqN_ready  output  1  command accepted this cycle.
REQ-009 SHALL have ports rspN_valid  output  1  one-cycle response pulse.
REQ-010 SHALL have ports rspN_err  output  1  command rejected, no access made.
REQ-011 SHALL have ports rspN_rdata  output  32  read data; 0 for writes and errors.
REQ-012 SHALL have port cfg_enable  output  1  counter cfg strobe, registered.
REQ-013 SHALL have port cfg_rd_wr  output  1  registered.
REQ-014 SHALL have port cfg_addr  output  5  registered.
REQ-015 SHALL have port cfg_wdata  output  32  registered.
REQ-016 SHALL have port cfg_rdata  input  32  counter read data, valid the cycle after the read strobe.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, CAPTURE, RESP, GAP.
REQ-019 In IDLE, reqN_ready SHALL be asserted combinationally only for the arbitration winner among valid requesters; handshake = valid & ready.
REQ-020 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; a lone valid requester always wins; the pointer updates only on handshake.
REQ-021 A requester SHALL hold valid and payload stable until ready; payload SHALL be latched at the handshake edge.
REQ-022 Illegal command = addr[1:0]!=0, or write to 0x10 (ROLLOVER_STATUS) or 0x14 (COUNT); it SHALL go IDLE->RESP with err=1, cfg_enable never asserted.
REQ-023 Legal command: handshake at cycle T -> ACCESS at T+1 with cfg_enable=1 for exactly one cycle and cfg_rd_wr/addr/wdata equal to the latched command.
REQ-024 Write: ACCESS -> RESP; rspN_valid=1, err=0, rdata=0 at T+2.
REQ-025 Read: ACCESS -> CAPTURE (T+2; cfg_rdata sampled at end of cycle) -> RESP; rspN_valid=1, rdata=captured value at T+3.
REQ-026 rspN_valid SHALL pulse exactly one cycle, only for the granted N; no backpressure on responses.
REQ-027 RESP -> GAP when GAP_CYCLES>0 and the command was legal; GAP SHALL hold GAP_CYCLES cycles via a 4-bit down-counter, then go to IDLE; otherwise RESP -> IDLE.
REQ-028 cfg_addr/cfg_rd_wr/cfg_wdata MAY hold their last values when cfg_enable=0.
REQ-029 Requests arriving while busy SHALL wait, not be dropped; ready stays low outside IDLE.

Reset
REQ-030 On rst low, asynchronously: state=IDLE, all outputs 0, RR pointer set so requester 0 wins the first contention, gap counter 0.
REQ-031 Reset mid-transaction SHALL abort it: cfg_enable drops immediately, no response is ever issued for the aborted command.
REQ-032 After rst rises, the first grant SHALL be possible in the first IDLE cycle.

Verification
REQ-033 req0 write addr 0x08 wdata 100 at T -> cfg_enable=1 at T+1 only, rd_wr=0, addr=0x08, wdata=100; rsp0_valid=1, err=0 at T+2.
REQ-034 req1 read addr 0x04, cfg_rdata=2 at T+2 -> cfg_enable=1, rd_wr=1 at T+1; rsp1_valid=1, rdata=2 at T+3.
REQ-035 Both valid continuously from reset -> grants 0,1,0,1; each response matches its requester.
REQ-036 req0 write to 0x14, then addr 0x05 -> no cfg_enable; rsp0_valid=1, err=1 one cycle after each handshake.
REQ-037 GAP_CYCLES=3, back-to-back legal writes -> cfg_enable low for >=3 cycles between strobes; GAP_CYCLES=0 -> next ready in the cycle after RESP.
REQ-038 rst low during ACCESS of a read -> cfg_enable=0 immediately, no rsp pulse; after release a new read completes normally.
